// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit
//   Stall/flush controller for the 5-stage pipeline. Operand forwarding fixes
//   most hazards by bypassing values. This block handles the hazards that a
//   bypass cannot fix:
//     - load-use,
//     - a branch compared in ID whose operand is still in flight in EX or Mem,
//     - multi-cycle mul/div occupying EX.
//   It also counts the cycles in which the PC is frozen. That count saturates.
//
// Parameters
//   MULDIV_LAT  total EX cycles a mul/div occupies (1..8)
//   CNT_W       width of StallCycles
//
// Ports
//   Clk, Rst        rising-edge clock; asynchronous active-high reset
//   IDrs/IDrt       source registers of the ID instruction
//   IDusesRt        ID instruction reads rt
//   IDBranch        ID instruction is a branch
//   IDMulDiv        ID instruction is a multi-cycle mul/div
//   BranchTaken     ID branch outcome; used only when not stalled
//   EXMemRead       EX instruction is a load
//   EXRegWrite      EX instruction writes a register
//   EXrd            EX destination register
//   MemRegWrite     Mem instruction writes a register
//   Memrd           Mem destination register
//   PCWrite         PC update enable
//   IFIDWrite       IF/ID write enable
//   BubbleID        zero the control bits that enter ID/EX
//   FlushIFID       clear IF/ID on a taken branch
//   EXHold          freeze ID/EX and the EX-stage state
//   StallCycles     saturating count of cycles with PCWrite=0
module hazard_stall_unit #(
  parameter int MULDIV_LAT = 4,
  parameter int CNT_W      = 16
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [4:0]       IDrs,
  input  logic [4:0]       IDrt,
  input  logic             IDusesRt,
  input  logic             IDBranch,
  input  logic             IDMulDiv,
  input  logic             BranchTaken,
  input  logic             EXMemRead,
  input  logic             EXRegWrite,
  input  logic [4:0]       EXrd,
  input  logic             MemRegWrite,
  input  logic [4:0]       Memrd,
  output logic             PCWrite,
  output logic             IFIDWrite,
  output logic             BubbleID,
  output logic             FlushIFID,
  output logic             EXHold,
  output logic [CNT_W-1:0] StallCycles
);

  // A single-cycle mul/div needs no hold, so MULDIV is never entered.
  localparam bit          HAS_HOLD = (MULDIV_LAT > 1);
  localparam int          LOADV    = HAS_HOLD ? MULDIV_LAT - 2 : 0;
  localparam logic [2:0]  CNT_LOAD = LOADV[2:0];

  typedef enum logic {RUN, MULDIV} state_t;

  state_t     state, state_nxt;
  logic [2:0] cnt, cnt_nxt;

  // r0 is hard-wired zero, so it never creates a dependence.
  function automatic logic match(input logic [4:0] r, input logic [4:0] rs,
                                 input logic [4:0] rt, input logic uses_rt);
    return (r != 5'd0) && ((r == rs) || (uses_rt && (r == rt)));
  endfunction

  logic load_use, br_ex, br_mem, hz;

  assign load_use = EXMemRead & match(EXrd, IDrs, IDrt, IDusesRt);
  assign br_ex    = IDBranch & EXRegWrite  & match(EXrd,  IDrs, IDrt, IDusesRt);
  assign br_mem   = IDBranch & MemRegWrite & match(Memrd, IDrs, IDrt, IDusesRt);
  assign hz       = load_use | br_ex | br_mem;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state <= RUN;
      cnt   <= 3'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    PCWrite   = 1'b1;
    IFIDWrite = 1'b1;
    BubbleID  = 1'b0;
    FlushIFID = 1'b0;
    EXHold    = 1'b0;
    unique case (state)
      RUN: begin
        if (hz) begin
          // The stall wins over a same-cycle mul/div. The mul/div enters
          // later, once its operands are clean.
          PCWrite   = 1'b0;
          IFIDWrite = 1'b0;
          BubbleID  = 1'b1;
        end else begin
          FlushIFID = BranchTaken & IDBranch;
          if (IDMulDiv && HAS_HOLD) begin
            state_nxt = MULDIV;
            cnt_nxt   = CNT_LOAD;
          end
        end
      end
      MULDIV: begin
        // The ID instruction is frozen. It is re-evaluated once RUN resumes,
        // so hz and BranchTaken are ignored here.
        PCWrite   = 1'b0;
        IFIDWrite = 1'b0;
        EXHold    = 1'b1;
        if (cnt == 3'd0) state_nxt = RUN;
        else             cnt_nxt   = cnt - 3'd1;
      end
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst)
      StallCycles <= '0;
    else if (!PCWrite && (StallCycles != {CNT_W{1'b1}}))
      StallCycles <= StallCycles + 1'b1;
  end

endmodule

// File: tb/tb_hazard_stall_unit.sv
module tb_hazard_stall_unit;

  localparam int LAT = 4;

  logic       Clk = 1'b0;
  logic       Rst;
  logic [4:0] IDrs, IDrt, EXrd, Memrd;
  logic       IDusesRt, IDBranch, IDMulDiv, BranchTaken;
  logic       EXMemRead, EXRegWrite, MemRegWrite;

  logic        a_pcw, a_ifid, a_bub, a_fl, a_exh;
  logic [15:0] a_sc;
  logic        b_pcw, b_ifid, b_bub, b_fl, b_exh;
  logic [3:0]  b_sc;

  always #5 Clk = ~Clk;

  hazard_stall_unit #(.MULDIV_LAT(LAT), .CNT_W(16)) dut (
    .Clk(Clk), .Rst(Rst), .IDrs(IDrs), .IDrt(IDrt), .IDusesRt(IDusesRt),
    .IDBranch(IDBranch), .IDMulDiv(IDMulDiv), .BranchTaken(BranchTaken),
    .EXMemRead(EXMemRead), .EXRegWrite(EXRegWrite), .EXrd(EXrd),
    .MemRegWrite(MemRegWrite), .Memrd(Memrd),
    .PCWrite(a_pcw), .IFIDWrite(a_ifid), .BubbleID(a_bub), .FlushIFID(a_fl),
    .EXHold(a_exh), .StallCycles(a_sc));

  hazard_stall_unit #(.MULDIV_LAT(LAT), .CNT_W(4)) dut4 (
    .Clk(Clk), .Rst(Rst), .IDrs(IDrs), .IDrt(IDrt), .IDusesRt(IDusesRt),
    .IDBranch(IDBranch), .IDMulDiv(IDMulDiv), .BranchTaken(BranchTaken),
    .EXMemRead(EXMemRead), .EXRegWrite(EXRegWrite), .EXrd(EXrd),
    .MemRegWrite(MemRegWrite), .Memrd(Memrd),
    .PCWrite(b_pcw), .IFIDWrite(b_ifid), .BubbleID(b_bub), .FlushIFID(b_fl),
    .EXHold(b_exh), .StallCycles(b_sc));

  // Reference model: remaining mul/div hold cycles plus two plain stall tallies.
  int hold_left;
  int sc16, sc4;
  int total, passed;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic bit dep(input logic [4:0] r);
    if (r == 0) return 1'b0;
    return (r == IDrs) || (IDusesRt && r == IDrt);
  endfunction

  // Expected {PCWrite, IFIDWrite, BubbleID, FlushIFID, EXHold}.
  function automatic logic [4:0] model_out();
    bit hz;
    hz = (EXMemRead && dep(EXrd)) ||
         (IDBranch && EXRegWrite && dep(EXrd)) ||
         (IDBranch && MemRegWrite && dep(Memrd));
    if (hold_left > 0) return 5'b00001;
    if (hz)            return 5'b00100;
    return {3'b110, BranchTaken & IDBranch, 1'b0};
  endfunction

  task automatic idle();
    IDrs = 0; IDrt = 0; IDusesRt = 0; IDBranch = 0; IDMulDiv = 0; BranchTaken = 0;
    EXMemRead = 0; EXRegWrite = 0; EXrd = 0; MemRegWrite = 0; Memrd = 0;
  endtask

  task automatic check_outs(input string tag);
    logic [4:0] e;
    e = model_out();
    chk({tag, ".outs"},   {a_pcw, a_ifid, a_bub, a_fl, a_exh}, e);
    chk({tag, ".outs4"},  {b_pcw, b_ifid, b_bub, b_fl, b_exh}, e);
  endtask

  // Caller sets inputs a little after a rising edge; one clock is then consumed.
  task automatic step(input string tag);
    logic [4:0] e;
    bit hz_free;
    #1;
    check_outs(tag);
    e = model_out();
    hz_free = (e == 5'b11000) || (e == 5'b11010);
    @(posedge Clk);
    if (!e[4]) begin
      if (sc16 < 65535) sc16++;
      if (sc4 < 15)     sc4++;
    end
    if (hold_left > 0)             hold_left--;
    else if (hz_free && IDMulDiv)  hold_left = LAT - 1;
    #1;
    chk({tag, ".sc"},  a_sc, sc16);
    chk({tag, ".sc4"}, b_sc, sc4);
  endtask

  task automatic pulse_reset(input string tag);
    Rst = 1'b1;
    #1;
    hold_left = 0; sc16 = 0; sc4 = 0;
    check_outs(tag);
    chk({tag, ".sc"},  a_sc, 0);
    chk({tag, ".sc4"}, b_sc, 0);
    #1 Rst = 1'b0;
  endtask

  initial begin
    total = 0; passed = 0;
    hold_left = 0; sc16 = 0; sc4 = 0;
    idle();
    Rst = 1'b1;

    // Reset state with idle inputs.
    #3;
    chk("rst.outs", {a_pcw, a_ifid, a_bub, a_fl, a_exh}, 5'b11000);
    chk("rst.sc",   a_sc, 0);
    chk("rst.sc4",  b_sc, 0);
    #9 Rst = 1'b0;
    @(posedge Clk); #1;

    // 1: load-use on rs gives a one-cycle bubble.
    EXMemRead = 1; EXrd = 8; IDrs = 8;
    step("t1.lu");
    chk("t1.sc_is_1", a_sc, 1);
    idle(); step("t1.after");

    // 2: r0 never matches; rt is ignored when not read.
    EXMemRead = 1; EXrd = 0; IDrs = 0;
    step("t2.r0");
    EXrd = 9; IDrt = 9; IDrs = 1; IDusesRt = 0;
    step("t2.nort");
    idle();

    // 3: branch on r9 behind a load. EX then Mem gives 2 stalls, then a taken branch flushes.
    IDBranch = 1; IDrt = 9; IDusesRt = 1; IDrs = 2;
    EXMemRead = 1; EXRegWrite = 1; EXrd = 9;
    step("t3.brEX");
    EXMemRead = 0; EXRegWrite = 0; EXrd = 0; MemRegWrite = 1; Memrd = 9;
    step("t3.brMem");
    MemRegWrite = 0; Memrd = 0; BranchTaken = 1;
    step("t3.flush");
    idle(); step("t3.noflush");

    // 4: mul/div gives 3 hold cycles. The counter ends at exactly 3.
    pulse_reset("t4.rst");
    IDMulDiv = 1; step("t4.c0");
    idle();
    for (int i = 1; i <= 3; i++) step($sformatf("t4.c%0d", i));
    step("t4.c4");
    chk("t4.sc_is_3", a_sc, 3);

    // 5: reset in the middle of a hold returns to RUN right away.
    IDMulDiv = 1; step("t5.c0");
    idle(); step("t5.c1");
    #2 pulse_reset("t5.midrst");
    step("t5.run");

    // 6: a sustained load-use saturates the 4-bit counter.
    pulse_reset("t6.rst");
    EXMemRead = 1; EXrd = 5; IDrs = 5;
    for (int i = 0; i < 20; i++) step("t6.sat");
    chk("t6.sc4_F", b_sc, 4'hF);
    chk("t6.sc_20", a_sc, 20);
    idle(); step("t6.idle");

    // Randomized traffic over a small register range, so that matches are frequent.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) < 2) begin
        #1 pulse_reset("rnd.rst");
      end
      IDrs        = 5'($urandom_range(0, 3));
      IDrt        = 5'($urandom_range(0, 3));
      IDusesRt    = 1'($urandom);
      IDBranch    = 1'($urandom);
      IDMulDiv    = ($urandom_range(0, 9) == 0);
      BranchTaken = 1'($urandom);
      EXMemRead   = 1'($urandom);
      EXRegWrite  = 1'($urandom);
      EXrd        = 5'($urandom_range(0, 3));
      MemRegWrite = 1'($urandom);
      Memrd       = 5'($urandom_range(0, 3));
      step("rnd");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
